// File: rtl/ram_port_arbiter.sv
// Three-way round-robin arbiter for the single BlockRam port, with a port-2
// burst lock and registered one-hot read-return strobes.
module ram_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  input  logic            lock,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            ram_re,
  output logic            ram_we,
  output logic [AW-1:0]   ram_read_addr,
  output logic [AW-1:0]   ram_write_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_q
);

  logic [1:0]    ptr;
  logic          locked;
  logic [2:0]    win;
  logic [1:0]    sel;
  logic [2:0]    vld_p1;
  logic [DW-1:0] rdata_hold;

  // Search order starts just after the last-granted port.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] pick;
    pick = 3'b000;
    case (p)
      2'd0: begin
        if (r[1])      pick = 3'b010;
        else if (r[2]) pick = 3'b100;
        else if (r[0]) pick = 3'b001;
      end
      2'd1: begin
        if (r[2])      pick = 3'b100;
        else if (r[0]) pick = 3'b001;
        else if (r[1]) pick = 3'b010;
      end
      default: begin
        if (r[0])      pick = 3'b001;
        else if (r[1]) pick = 3'b010;
        else if (r[2]) pick = 3'b100;
      end
    endcase
    return pick;
  endfunction

  always_comb begin
    win = 3'b000;
    if (reset) begin
      if (locked && req[2]) win = 3'b100;
      else                  win = rr_pick(req, ptr);
    end
    if (win[1])      sel = 2'd1;
    else if (win[2]) sel = 2'd2;
    else             sel = 2'd0;
  end

  assign gnt = win;

  always_comb begin
    ram_re         = 1'b0;
    ram_we         = 1'b0;
    ram_read_addr  = '0;
    ram_write_addr = '0;
    ram_wdata      = '0;
    if (|win) begin
      if (we[sel]) begin
        ram_we         = 1'b1;
        ram_write_addr = addr[int'(sel)*AW +: AW];
        ram_wdata      = wdata[int'(sel)*DW +: DW];
      end else begin
        ram_re         = 1'b1;
        ram_read_addr  = addr[int'(sel)*AW +: AW];
      end
    end
  end

  // Grant edge -> p1: the one-hot read tag becomes next cycle's rvalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr    <= 2'd2;
      locked <= 1'b0;
      vld_p1 <= 3'b000;
    end else begin
      if (|win) ptr <= sel;
      if (!lock || !req[2]) locked <= 1'b0;
      else if (win[2])      locked <= 1'b1;
      vld_p1 <= win & ~we;
    end
  end

  always_ff @(posedge clock) begin
    if (|vld_p1) rdata_hold <= ram_q;
  end

  assign rvalid = vld_p1;
  assign rdata  = (|vld_p1) ? ram_q : rdata_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: BlockRam model plus a cycle-level reference of
// the arbitration/lock/read-return rules, directed steps then random traffic.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, we;
  logic [47:0] addr;
  logic [47:0] wdata;
  logic        lock;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        ram_re, ram_we;
  logic [15:0] ram_read_addr, ram_write_addr, ram_wdata, ram_q;

  ram_port_arbiter #(.AW(16), .DW(16)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_read_addr(ram_read_addr),
    .ram_write_addr(ram_write_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];

  always @(posedge clock) begin
    if (ram_we) mem[ram_write_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_read_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference state
  int          mptr;
  bit          mlocked;
  bit          pend_valid;
  int          pend_port;
  logic [15:0] pend_data;
  bit          have_rd;
  logic [15:0] last_rd;
  int          last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr = 2;
    mlocked = 0;
    pend_valid = 0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    req[p] = r;
    we[p] = w;
    addr[p*16 +: 16] = a;
    wdata[p*16 +: 16] = d;
  endtask

  task automatic step();
    int w;
    logic [2:0] eg, ev;
    logic [15:0] a;
    @(negedge clock);
    w = -1;
    if (reset) begin
      if (mlocked && req[2]) w = 2;
      else begin
        for (int k = 1; k <= 3; k++) begin
          int p;
          p = (mptr + k) % 3;
          if (w < 0 && req[p]) w = p;
        end
      end
    end
    eg = 3'b000;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    if (w >= 0 && we[w]) begin
      chk("ram_we", ram_we, 1);
      chk("ram_re_on_write", ram_re, 0);
      chk("ram_write_addr", ram_write_addr, addr[w*16 +: 16]);
      chk("ram_wdata", ram_wdata, wdata[w*16 +: 16]);
    end else if (w >= 0) begin
      chk("ram_re", ram_re, 1);
      chk("ram_we_on_read", ram_we, 0);
      chk("ram_read_addr", ram_read_addr, addr[w*16 +: 16]);
    end else begin
      chk("idle_re", ram_re, 0);
      chk("idle_we", ram_we, 0);
    end
    ev = 3'b000;
    if (pend_valid) ev[pend_port] = 1'b1;
    chk("rvalid", rvalid, ev);
    if (pend_valid)   chk("rdata", rdata, pend_data);
    else if (have_rd) chk("rdata_hold", rdata, last_rd);
    chk("ptr", dut.ptr, mptr);
    chk("ptr_range", dut.ptr != 2'd3, 1);
    last_w = w;
    @(posedge clock);
    if (reset) begin
      if (pend_valid) begin
        last_rd = pend_data;
        have_rd = 1;
      end
      pend_valid = 0;
      if (w >= 0) begin
        a = addr[w*16 +: 16];
        mptr = w;
        if (we[w]) ref_mem[a] = wdata[w*16 +: 16];
        else begin
          pend_valid = 1;
          pend_port = w;
          pend_data = ref_mem[a];
        end
      end
      if (!lock || !req[2]) mlocked = 0;
      else if (w == 2)      mlocked = 1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; lock = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'hA5C3;
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    model_reset();
    have_rd = 0;
    last_rd = 0;
    last_w = -1;

    // Reset held with all ports requesting, then released: grants 0,1,2,0.
    set_port(0, 1, 0, 16'h0010, 0);
    set_port(1, 1, 0, 16'h0020, 0);
    set_port(2, 1, 0, 16'h0030, 0);
    step(); step();
    reset = 1'b1;
    repeat (4) step();
    req = 0;
    step();

    // Write then read-after-write from a different port.
    set_port(1, 1, 1, 16'h0040, 16'hBEEF);
    step();
    req = 0;
    set_port(0, 1, 0, 16'h0040, 0);
    step();
    req = 0;
    step();

    // Burst lock: port 2 writes 8 words while ports 0/1 wait.
    set_port(1, 1, 0, 16'h0050, 0);
    step();
    set_port(0, 1, 0, 16'h0011, 0);
    set_port(1, 1, 0, 16'h0021, 0);
    lock = 1;
    for (int i = 0; i < 8; i++) begin
      set_port(2, 1, 1, 16'h0100 + 16'(i), 16'($urandom));
      step();
    end
    lock = 0;
    req[2] = 0;
    step(); step();
    req = 0;
    set_port(0, 1, 0, 16'h0103, 0);
    step();
    req = 0;

    // Single requester, continuous reads.
    set_port(1, 1, 0, 16'h0033, 0);
    repeat (5) step();
    req = 0;
    step(); step();

    // Reset lands while a read is in flight.
    set_port(0, 1, 0, 16'h0010, 0);
    step();
    reset = 1'b0;
    model_reset();
    req = 3'b111;
    step(); step();
    reset = 1'b1;
    req = 0;
    step(); step();

    // Idle cycles.
    repeat (3) step();

    // Random traffic, each requester holding until granted.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 3; p++) begin
        if (!(req[p] && last_w != p))
          set_port(p, ($urandom % 3) != 0, $urandom % 2, 16'h0200 + 16'($urandom % 16), 16'($urandom));
      end
      if ($urandom % 10 == 0) lock = ~lock;
      step();
    end
    req = 0;
    lock = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single BlockRam read/write port among three requesters: port 0 is instruction fetch (ProgramCounter), port 1 is datapath load/store, and port 2 is the external program loader/debug.
- Grants at most one access per cycle using round-robin arbitration, with a burst lock for port 2.
- Returns read data one cycle after the grant, with a per-port valid strobe.
- Sits between the requesters and BlockRam, replacing the direct PC/datapath wiring to the RAM port.

Parameters:
AW, 16, address width (BlockRam read_addr/write_addr)
DW, 16, data width (BlockRam data/q)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req  in  3  per-port request, bit i = port i
we  in  3  per-port write flag (1 = write, 0 = read), valid while req[i]
addr  in  3*AW  per-port address, port i at [i*AW +: AW]
wdata  in  3*DW  per-port write data, port i at [i*DW +: DW]
lock  in  1  port 2 burst lock
gnt  out  3  one-hot grant, combinational, same cycle as access
rvalid  out  3  one-hot, registered; read data valid for port i
rdata  out  DW  read data, shared by all ports, qualified by rvalid
ram_re  out  1  BlockRam read enable
ram_we  out  1  BlockRam write enable
ram_read_addr  out  AW  BlockRam read address
ram_write_addr  out  AW  BlockRam write address
ram_wdata  out  DW  BlockRam write data
ram_q  in  DW  BlockRam registered read data (1-cycle latency)

Behaviour:
- Reset (reset=0, asynchronous): last-grant pointer = 2, so port 0 wins first. locked=0, rvalid=0, read tag cleared. gnt, ram_re and ram_we are forced 0 while reset=0.
- Handshake: requester raises req[i] and holds req/we/addr/wdata stable until it sees gnt[i]=1 in the same cycle. The access is committed on that rising edge. Dropping req before grant is legal, and nothing is issued.
- Arbitration each cycle, among asserted req bits:
  - If locked=1 and req[2]=1, port 2 wins.
  - Otherwise the winner is the first asserted port after the last-grant pointer, in order (ptr+1, ptr+2, ptr+3) mod 3.
- Exactly one gnt bit is high when any req is high; gnt=0 when req=0. The pointer updates to the winner on every grant and holds when idle.
- Lock:
  - locked is set on the clock edge where port 2 is granted and lock=1.
  - locked is cleared on any edge where lock=0 or req[2]=0.
  - While locked, ports 0 and 1 stall indefinitely; unbounded starvation under lock is accepted, because the loader owns the RAM during a load.
- RAM drive for the granted port:
  - Write: ram_we=1, ram_write_addr=addr, ram_wdata=wdata, ram_re=0.
  - Read: ram_re=1, ram_read_addr=addr, ram_we=0.
  - With no grant: ram_re=ram_we=0, address/data outputs are don't-care (drive 0).
- Read return:
  - The granted read port index is registered (tag).
  - Next cycle: rvalid[tag]=1 for exactly one cycle and rdata=ram_q. Total latency is grant edge + 1.
  - Writes never produce rvalid.
  - Back-to-back reads from any mix of ports give one rvalid per cycle, in grant order.
- Read-after-write to the same address on consecutive cycles returns the new data. BlockRam write-then-read ordering is relied on, with no bypass.
- Idle cycles: rvalid=0; rdata holds its last value.
- Reset mid-operation: a read in flight is dropped (no rvalid after release). A write granted on the same edge that reset asserts is not guaranteed.
- Widths: no arithmetic beyond the mod-3 pointer; the pointer is a 2-bit register, and value 3 is unreachable (a bench assertion covers it).

Test Plan:
- Reset release with req=3'b111, all reads, addr0=0x0010, addr1=0x0020, addr2=0x0030 → grants in order 0,1,2,0 on consecutive cycles. rvalid 0,1,2 follow one cycle later, with rdata = RAM contents at 0x0010/0x0020/0x0030.
- Port 1 writes 0xBEEF to 0x0040, then port 0 reads 0x0040 next cycle → ram_we pulse with write_addr=0x0040, then rvalid[0] with rdata=0xBEEF.
- lock=1 with port 2 writing 0x0100..0x0107 for 8 cycles while req[0]=req[1]=1 → gnt=3'b100 for all 8 cycles, and ports 0/1 are never granted. After lock drops, port 0 is granted first, then port 1.
- Single requester port 1 reads continuously for 5 cycles → gnt[1]=1 every cycle, rvalid[1]=1 on cycles 2–6, pointer stays at 1.
- reset asserted the cycle after a port 0 read grant → no rvalid after reset release; gnt=0 and ram_re=0 during reset.
- req=0 for 3 cycles → ram_re=ram_we=0, rvalid=0, rdata unchanged.
